johnson_burst_sequencer: RTL



---
 rtl/johnson_pkg.sv | 19 +
 rtl/johnson_step_core.sv | 110 +++++++++++
 rtl/johnson_burst_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// Purpose: shared types and constants for the Johnson burst sequencer and its step core.
// Latency: none (declarations only).
// Backpressure: not applicable.
package johnson_pkg;

    localparam int JOHNSON_WIDTH = 8;
    localparam int JOHNSON_CNT_W = 8;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/johnson_step_core.sv
// Purpose: Johnson ring register with step (fwd/rev) and clear, plus decoded ring position.
// Latency: one edge per step; pos_o is combinational from the register.
// Backpressure: none; en_i gates stepping. Optional macro ILLEGAL_STATE_RECOVER_EN adds err_o.
module johnson_step_core
    import johnson_pkg::*;
#(
    parameter  int WIDTH = JOHNSON_WIDTH,
    localparam int POS_W = $clog2(2 * WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] phase_o,
    output logic [POS_W-1:0] pos_o
`ifdef ILLEGAL_STATE_RECOVER_EN
    ,
    output logic             err_o
`endif
);

    localparam int ONES_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  phase_q;
    logic [WIDTH-1:0]  phase_d;
    logic [ONES_W-1:0] ones;

`ifdef ILLEGAL_STATE_RECOVER_EN
    logic [ONES_W-1:0] edges;
    logic              illegal;
    logic              err_q;
    logic              err_d;

    // A legal ring value has at most one rising and one falling boundary, i.e. <= 2 bit changes around the ring.
    always_comb begin
        edges = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edges = edges + ONES_W'(phase_q[i] ^ phase_q[(i + 1) % WIDTH]);
        end
        illegal = (edges > ONES_W'(2));
    end

    // Sticky error: set by any illegal pattern, cleared by an honoured clear (set wins on a tie).
    always_comb begin
        err_d = err_q;
        if (clr_i) begin
            err_d = 1'b0;
        end
        if (illegal) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

    // Next ring value: clear has priority over stepping; a corrupt pattern is flushed to zero.
    always_comb begin
        phase_d = phase_q;
        if (clr_i) begin
            phase_d = '0;
        end else if (en_i) begin
            if (dir_i == DIR_REV) begin
                phase_d = {~phase_q[0], phase_q[WIDTH-1:1]};
            end else begin
                phase_d = {phase_q[WIDTH-2:0], ~phase_q[WIDTH-1]};
            end
        end
`ifdef ILLEGAL_STATE_RECOVER_EN
        if (illegal) begin
            phase_d = '0;
        end
`endif
    end

    // Ring register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Position decode: filling half counts ones, draining half counts down from 2*WIDTH.
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + ONES_W'(phase_q[i]);
        end
        if (!phase_q[WIDTH-1]) begin
            pos_o = POS_W'(ones);
        end else begin
            pos_o = POS_W'(2 * WIDTH - int'(ones));
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/johnson_burst_sequencer.sv
// Purpose: start/busy/done controller stepping a Johnson ring a programmed number of times.
// Latency: accept at edge 0, steps on edges 1..N, done_o high in the cycle after the last step.
// Backpressure: hold_i pauses stepping; start_i while busy is dropped. Optional macro ILLEGAL_STATE_RECOVER_EN.
module johnson_burst_sequencer
    import johnson_pkg::*;
#(
    parameter  int WIDTH = JOHNSON_WIDTH,
    parameter  int CNT_W = JOHNSON_CNT_W,
    localparam int POS_W = $clog2(2 * WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             dir_i,
    input  logic [CNT_W-1:0] steps_i,
    input  logic             hold_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] phase_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [POS_W-1:0] pos_o
`ifdef ILLEGAL_STATE_RECOVER_EN
    ,
    output logic             err_o
`endif
);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_d;
    logic             dir_q;
    logic             dir_d;
    logic             step_en;
    logic             clr_en;

    // Burst control: accept in IDLE, step whenever not held, finish when the last step is taken.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        step_en = 1'b0;
        clr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    // Start beats clear; a zero-length burst just reports completion.
                    if (steps_i != '0) begin
                        dir_d   = dir_i;
                        rem_d   = steps_i;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end else if (clr_i) begin
                    clr_en = 1'b1;
                end
            end
            RUN, PAUSE: begin
                // Leaving PAUSE steps in the same cycle hold_i drops, so each held cycle costs exactly one.
                if (hold_i) begin
                    state_d = PAUSE;
                end else begin
                    step_en = 1'b1;
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = (rem_q == CNT_W'(1)) ? DONE : RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dir_q   <= DIR_FWD;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    assign busy_o = (state_q == RUN) || (state_q == PAUSE);
    assign done_o = (state_q == DONE);

    // If the core flushes an illegal pattern mid-burst the step still counts, so the burst resumes from zero.
    johnson_step_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (step_en),
        .dir_i   (dir_q),
        .clr_i   (clr_en),
        .phase_o (phase_o),
        .pos_o   (pos_o)
`ifdef ILLEGAL_STATE_RECOVER_EN
        ,
        .err_o   (err_o)
`endif
    );

endmodule
